// File: rtl/mat_mult_seq.sv
// Sequential NxN unsigned matrix multiplier, Res = A x B.
// One multiply-accumulate per clock. Operands are captured on start, the
// result matrix is built in an internal buffer and copied to res in one shot,
// so res never exposes partial sums.
//
// state | meaning
// IDLE  | waiting for start, in_ready=1
// CALC  | one MAC per edge, k fastest, then j, then i
// DONE  | res_valid=1, holding until res_ready
module mat_mult_seq #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int ACC_W = 2*DW + $clog2(N),
    parameter int SAT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] a_flat,
    input  logic [N*N*DW-1:0] b_flat,
    output logic [N*N*DW-1:0] res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    localparam int NE = N*N;
    localparam int FW = NE*DW;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0]    LAST = CW'(N-1);
    localparam logic [ACC_W-1:0] MAXV = ACC_W'({DW{1'b1}});

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [FW-1:0]     abuf;
    logic [FW-1:0]     bbuf;
    logic [FW-1:0]     rbuf;
    logic [FW-1:0]     rbuf_upd;
    logic [CW-1:0]     i;
    logic [CW-1:0]     j;
    logic [CW-1:0]     k;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  sum;
    logic [DW-1:0]     a_el;
    logic [DW-1:0]     b_el;
    logic [DW-1:0]     narrowed;
    logic              capture;
    logic              last_k;
    logic              last_all;
    int                a_idx;
    int                b_idx;
    int                r_idx;

    // MAC datapath: operand select, full-width product and sum, narrowing,
    // and the result buffer as it will look once the current element lands
    always_comb begin
        a_idx    = int'(i)*N + int'(k);
        b_idx    = int'(k)*N + int'(j);
        r_idx    = int'(i)*N + int'(j);
        a_el     = abuf[(NE-1-a_idx)*DW +: DW];
        b_el     = bbuf[(NE-1-b_idx)*DW +: DW];
        prod     = ACC_W'(a_el) * ACC_W'(b_el);
        sum      = acc + prod;
        narrowed = ((SAT != 0) && (sum > MAXV)) ? {DW{1'b1}} : sum[DW-1:0];
        rbuf_upd = rbuf;
        rbuf_upd[(NE-1-r_idx)*DW +: DW] = narrowed;
        last_k   = (k == LAST);
        last_all = last_k && (j == LAST) && (i == LAST);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_all) state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, index counters, accumulator and result buffers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abuf <= '0;
            bbuf <= '0;
            rbuf <= '0;
            res  <= '0;
            acc  <= '0;
            i    <= '0;
            j    <= '0;
            k    <= '0;
        end else if (capture) begin
            abuf <= a_flat;
            bbuf <= b_flat;
            acc  <= '0;
            i    <= '0;
            j    <= '0;
            k    <= '0;
        end else if (state == CALC) begin
            if (last_k) begin
                rbuf <= rbuf_upd;
                acc  <= '0;
                k    <= '0;
                if (j == LAST) begin
                    j <= '0;
                    i <= (i == LAST) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end else begin
                acc <= sum;
                k   <= k + 1'b1;
            end
            // the final element is still in flight, so publish the updated view
            if (last_all) res <= rbuf_upd;
        end
    end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq: a transaction-level model of the 2x2
// instance checked every cycle, plus literal checks on 2x2 wrap/saturate and
// a 3x3 instance.
module tb_mat_mult_seq;

    localparam logic [31:0] A1 = 32'h01020304;
    localparam logic [31:0] B1 = 32'h05060708;
    localparam logic [31:0] FF = 32'hFFFFFFFF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 2x2 wrap instance, fully modelled
    logic        start = 1'b0, rr = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] res;
    logic        res_valid, in_ready, busy;

    // 2x2 saturating instance
    logic        start_s = 1'b0, rr_s = 1'b1;
    logic [31:0] a_s = '0, b_s = '0;
    logic [31:0] res_s;
    logic        res_valid_s, in_ready_s, busy_s;

    // 3x3 wrap instance
    logic        start_3 = 1'b0, rr_3 = 1'b1;
    logic [71:0] a_3 = '0, b_3 = '0;
    logic [71:0] res_3;
    logic        res_valid_3, in_ready_3, busy_3;

    mat_mult_seq #(.N(2), .DW(8), .SAT(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_ready(in_ready),
        .a_flat(a), .b_flat(b), .res(res), .res_valid(res_valid),
        .res_ready(rr), .busy(busy));

    mat_mult_seq #(.N(2), .DW(8), .SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .start(start_s), .in_ready(in_ready_s),
        .a_flat(a_s), .b_flat(b_s), .res(res_s), .res_valid(res_valid_s),
        .res_ready(rr_s), .busy(busy_s));

    mat_mult_seq #(.N(3), .DW(8), .SAT(0)) dut3 (
        .clk(clk), .reset(reset), .start(start_3), .in_ready(in_ready_3),
        .a_flat(a_3), .b_flat(b_3), .res(res_3), .res_valid(res_valid_3),
        .res_ready(rr_3), .busy(busy_3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference 2x2 product, element (r,c) at byte 3-(2r+c), low 8 bits kept
    function automatic logic [31:0] mm2(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] out;
        int s;
        out = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                s = 0;
                for (int m = 0; m < 2; m++)
                    s += int'((x >> ((3 - (r*2 + m)) * 8)) & 32'hFF)
                       * int'((y >> ((3 - (m*2 + c)) * 8)) & 32'hFF);
                out = out | (32'(s & 255) << ((3 - (r*2 + c)) * 8));
            end
        return out;
    endfunction

    // Transaction model: idle / computing for 8 edges / holding a result
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic [31:0] m_res   = '0;
    logic [31:0] m_pend  = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_pend  <= mm2(a, b);
                    m_cnt   <= 7;
                    m_phase <= 1;
                end
                1: if (m_cnt == 0) begin
                    m_res   <= m_pend;
                    m_phase <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (rr) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cyc_res", 72'(res), 72'(m_res));
        chk("cyc_res_valid", 72'(res_valid), 72'(m_phase == 2));
        chk("cyc_in_ready", 72'(in_ready), 72'(m_phase == 0));
        chk("cyc_busy", 72'(busy), 72'(m_phase != 0));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Start one 2x2 operation, wait for res_valid, check latency and result
    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp);
        int n;
        a = x;
        b = y;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        chk({name, "_latency"}, 72'(n), 72'd8);
        chk({name, "_res"}, 72'(res), 72'(exp));
    endtask

    initial begin
        int n;
        int n2;
        step();
        step();
        chk("reset_res", 72'(res), 72'd0);
        chk("reset_in_ready", 72'(in_ready), 72'd1);
        reset = 1'b0;
        step();

        chk("model_ab", 72'(mm2(A1, B1)), 72'h13162B32);
        chk("model_ba", 72'(mm2(B1, A1)), 72'h17221F2E);
        chk("model_ff", 72'(mm2(FF, FF)), 72'h02020202);

        // basic product, single-cycle valid with res_ready high
        rr = 1'b1;
        run_op("t1", A1, B1, 32'h13162B32);
        step();
        chk("t1_valid_one_cycle", 72'(res_valid), 72'd0);
        chk("t1_res_held", 72'(res), 72'h13162B32);

        // wrap on all-FF operands, saturate on the other instance
        run_op("t2_wrap", FF, FF, 32'h02020202);
        a_s = FF;
        b_s = FF;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        n = 0;
        while (!res_valid_s && n < 100) begin
            step();
            n++;
        end
        chk("t2_sat_latency", 72'(n), 72'd8);
        chk("t2_sat_res", 72'(res_s), 72'hFFFFFFFF);

        // zero operands: zero result, same latency
        run_op("t2_zero", 32'd0, 32'd0, 32'd0);
        step();

        // backpressure with start pulsed during DONE
        rr = 1'b0;
        run_op("t3", A1, B1, 32'h13162B32);
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t3_valid_hold", 72'(res_valid), 72'd1);
            chk("t3_res_hold", 72'(res), 72'h13162B32);
            chk("t3_in_ready_low", 72'(in_ready), 72'd0);
        end
        start = 1'b0;
        rr = 1'b1;
        step();
        chk("t3_released", 72'(in_ready), 72'd1);
        chk("t3_valid_dropped", 72'(res_valid), 72'd0);

        // asynchronous reset after edge 4 of an operation
        a = 32'h0A0B0C0D;
        b = B1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("t4_busy_before", 72'(busy), 72'd1);
        reset = 1'b1;
        #1;
        chk("t4_res", 72'(res), 72'd0);
        chk("t4_res_valid", 72'(res_valid), 72'd0);
        chk("t4_busy", 72'(busy), 72'd0);
        chk("t4_in_ready", 72'(in_ready), 72'd1);
        step();
        reset = 1'b0;
        step();
        run_op("t4_rerun", A1, B1, 32'h13162B32);
        step();

        // 3x3 identity times B
        a_3 = 72'h010000000100000001;
        b_3 = 72'h010203040506070809;
        start_3 = 1'b1;
        step();
        start_3 = 1'b0;
        a_3 = 72'h090909090909090909;
        n = 0;
        while (!res_valid_3 && n < 200) begin
            step();
            n++;
        end
        chk("t5_latency", 72'(n), 72'd27);
        chk("t5_res", res_3, 72'h010203040506070809);

        // back-to-back with start and res_ready held high, operands swapped
        rr = 1'b1;
        a = A1;
        b = B1;
        start = 1'b1;
        step();
        a = B1;
        b = A1;
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        chk("t6_first_latency", 72'(n), 72'd8);
        chk("t6_first_res", 72'(res), 72'h13162B32);
        n2 = 0;
        do begin
            step();
            n2++;
        end while (!res_valid && n2 < 100);
        chk("t6_gap", 72'(n2), 72'd10);
        chk("t6_second_res", 72'(res), 72'h17221F2E);
        start = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
